// File: rtl/i2s_pkg.sv
// Shared I2S timing definitions for the audio input and output paths.
// Divider bit positions are derived from the system clock so MCLK:BCLK:LRCLK = 256:64:1.
package i2s_pkg;

  localparam int unsigned W_SLOT = 32;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_t;

  function automatic int mclk_bit(input int clk_mhz);
    return $clog2(clk_mhz - 4) - 4;
  endfunction

  function automatic int bclk_bit(input int clk_mhz);
    return mclk_bit(clk_mhz) + 2;
  endfunction

  function automatic int lrclk_bit(input int clk_mhz);
    return bclk_bit(clk_mhz) + 6;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running I2S clock divider: MCLK/BCLK/LRCLK, slot index and the per-bit
// sample strobe (last clk of the BCLK high phase).
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int clk_mhz = 50
) (
  input  logic       clk,
  input  logic       reset,
  output logic       mclk,
  output logic       bclk,
  output logic       lrclk,
  output logic       strobe,
  output logic [4:0] slot
);

  localparam int MCLK_BIT  = mclk_bit(clk_mhz);
  localparam int BCLK_BIT  = bclk_bit(clk_mhz);
  localparam int LRCLK_BIT = lrclk_bit(clk_mhz);

  logic [LRCLK_BIT-1:0] clk_div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_div <= '0;
    end else begin
      clk_div <= clk_div + 1'b1;
    end
  end

  // At the lowest supported clock rates MCLK runs at the system clock itself.
  if (MCLK_BIT == 0) begin : g_mclk_pass
    assign mclk = clk;
  end else begin : g_mclk_div
    assign mclk = clk_div[MCLK_BIT-1];
  end

  assign bclk   = clk_div[BCLK_BIT-1];
  assign lrclk  = clk_div[LRCLK_BIT-1];
  assign strobe = &clk_div[BCLK_BIT-1:0];
  assign slot   = clk_div[LRCLK_BIT-2:BCLK_BIT];

endmodule

// File: rtl/i2s_audio_in.sv
// I2S master receiver: drives MCLK/BCLK/LRCLK, deserialises SD into left/right samples.
// Define I2S_AUDIO_IN_SYNC_EN to pass sdata through a 2-flop synchroniser.
module i2s_audio_in
  import i2s_pkg::*;
#(
  parameter int          clk_mhz             = 50,
  parameter int unsigned out_res             = 16,
  parameter int unsigned align_right         = 0,
  parameter int unsigned offset_by_one_cycle = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      mclk,
  output logic                      bclk,
  output logic                      lrclk,
  input  logic                      sdata,
  output logic signed [out_res-1:0] left,
  output logic signed [out_res-1:0] right,
  output logic                      sample_valid
);

  logic              strobe;
  logic [4:0]        slot;
  logic              sdata_s;
  logic [W_SLOT-2:0] shift;
  logic [W_SLOT-1:0] word;
  logic [out_res-1:0] extracted;
  logic [out_res-1:0] left_hold;
  logic              primed;
  logic              word_done;
  channel_t          word_ch;

  i2s_clk_gen #(
    .clk_mhz(clk_mhz)
  ) u_clk_gen (
    .clk    (clk),
    .reset  (reset),
    .mclk   (mclk),
    .bclk   (bclk),
    .lrclk  (lrclk),
    .strobe (strobe),
    .slot   (slot)
  );

`ifdef I2S_AUDIO_IN_SYNC_EN
  logic [1:0] sdata_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdata_sync <= '0;
    end else begin
      sdata_sync <= {sdata_sync[0], sdata};
    end
  end

  assign sdata_s = sdata_sync[1];
`else
  assign sdata_s = sdata;
`endif

  assign word = {shift, sdata_s};

  always_comb begin
    extracted = '0;
    for (int unsigned i = 0; i < out_res; i++) begin
      extracted[i] = (align_right != 0) ? word[i] : word[W_SLOT-out_res+i];
    end
  end

  // With the one-BCLK offset the first slot-0 strobe after reset would close
  // a word holding a single bit; hold off until a full half has been shifted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      primed <= 1'b0;
    end else if (strobe && slot == 5'd31) begin
      primed <= 1'b1;
    end
  end

  always_comb begin
    word_done = 1'b0;
    word_ch   = CH_LEFT;
    if (offset_by_one_cycle != 0) begin
      word_done = strobe && slot == 5'd0 && primed;
      word_ch   = channel_t'(~lrclk);
    end else begin
      word_done = strobe && slot == 5'd31;
      word_ch   = channel_t'(lrclk);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift        <= '0;
      left_hold    <= '0;
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (strobe) begin
        shift <= word[W_SLOT-2:0];
      end
      if (word_done) begin
        if (word_ch == CH_RIGHT) begin
          right        <= $signed(extracted);
          left         <= $signed(left_hold);
          sample_valid <= 1'b1;
        end else begin
          left_hold <= extracted;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_in.sv
// Self-checking bench: two receiver configurations fed by queue-based I2S ADC models.
`timescale 1ns/1ps
module tb_i2s_audio_in;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               mclk0, bclk0, lrclk0, sv0, sd0;
  logic signed [15:0] left0, right0;
  logic               mclk1, bclk1, lrclk1, sv1, sd1;
  logic signed [23:0] left1, right1;

  // DUT0: 50 MHz, 16-bit, MSB-aligned, standard I2S offset
  i2s_audio_in #(
    .clk_mhz(50), .out_res(16), .align_right(0), .offset_by_one_cycle(1)
  ) dut0 (
    .clk(clk), .reset(reset), .mclk(mclk0), .bclk(bclk0), .lrclk(lrclk0),
    .sdata(sd0), .left(left0), .right(right0), .sample_valid(sv0)
  );

  // DUT1: 16 MHz, 24-bit, LSB-aligned, MSB at the LRCLK edge
  i2s_audio_in #(
    .clk_mhz(16), .out_res(24), .align_right(1), .offset_by_one_cycle(0)
  ) dut1 (
    .clk(clk), .reset(reset), .mclk(mclk1), .bclk(bclk1), .lrclk(lrclk1),
    .sdata(sd1), .left(left1), .right(right1), .sample_valid(sv1)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] dir_l[4] = '{32'h1234_5678, 32'h8000_0000, 32'hFFFF_FF00, 32'h0000_0100};
  logic [31:0] dir_r[4] = '{32'hABCD_EF01, 32'h7FFF_FFFF, 32'h0000_0100, 32'hFFFF_FF00};

  bit          bitq[2][$];
  logic [31:0] expl[2][$];
  logic [31:0] expr[2][$];
  logic [31:0] cur_l[2];
  int          frame_idx[2];
  bit          prev_lr[2];

  int cyc;
  int last_sv[2];
  int nsv[2];
  int first_lat[2] = '{1040, 256};
  int frame_len[2] = '{1024, 256};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ADC model: each half-frame's word is queued MSB first; DUT0's device
  // inserts one extra bit of delay (MSB one BCLK after the LRCLK edge).
  task automatic push_word(input int d, input bit ch);
    logic [31:0] w;
    if (!ch) begin
      w = (frame_idx[d] < 4) ? dir_l[frame_idx[d]] : $urandom;
      cur_l[d] = w;
    end else begin
      w = (frame_idx[d] < 4) ? dir_r[frame_idx[d]] : $urandom;
      expl[d].push_back(cur_l[d]);
      expr[d].push_back(w);
      frame_idx[d]++;
    end
    for (int i = 31; i >= 0; i--) bitq[d].push_back(w[i]);
  endtask

  task automatic drive(input int d);
    bit b;
    b = (bitq[d].size() > 0) ? bitq[d][0] : 1'b0;
    if (d == 0) sd0 = b;
    else        sd1 = b;
  endtask

  task automatic bfm_init(input int d);
    bitq[d].delete();
    expl[d].delete();
    expr[d].delete();
    frame_idx[d] = 0;
    prev_lr[d]   = 1'b0;
    if (d == 0) bitq[d].push_back(1'b0);
    push_word(d, 1'b0);
    drive(d);
  endtask

  task automatic bfm_step(input int d, input bit lr);
    bit dummy;
    if (bitq[d].size() > 0) dummy = bitq[d].pop_front();
    if (lr != prev_lr[d]) begin
      prev_lr[d] = lr;
      push_word(d, lr);
    end
    drive(d);
  endtask

  always @(negedge reset) begin
    #1;
    bfm_init(0);
    bfm_init(1);
  end

  always @(negedge bclk0) begin
    #1;
    if (!reset) bfm_step(0, lrclk0);
  end

  always @(negedge bclk1) begin
    #1;
    if (!reset) bfm_step(1, lrclk1);
  end

  function automatic logic [63:0] ext(input int d, input logic [31:0] w);
    if (d == 0) return 64'(w >> 16);
    return 64'(w & 32'h00FF_FFFF);
  endfunction

  task automatic check_sv(input int d);
    logic [31:0]  el, er;
    logic [63:0]  ol, orr;
    ol  = (d == 0) ? 64'($unsigned(left0))  : 64'($unsigned(left1));
    orr = (d == 0) ? 64'($unsigned(right0)) : 64'($unsigned(right1));
    if (last_sv[d] < 0) chk($sformatf("first_latency%0d", d), 64'(cyc), 64'(first_lat[d]));
    else chk($sformatf("sv_period%0d", d), 64'(cyc - last_sv[d]), 64'(frame_len[d]));
    last_sv[d] = cyc;
    nsv[d]++;
    if (expl[d].size() == 0) begin
      chk($sformatf("expect_queue%0d", d), 64'(0), 64'(1));
    end else begin
      el = expl[d].pop_front();
      er = expr[d].pop_front();
      chk($sformatf("left%0d", d), ol, ext(d, el));
      chk($sformatf("right%0d", d), orr, ext(d, er));
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("mclk1_follows_clk", 64'(mclk1), 64'(clk));
      @(negedge clk);
      chk("clocks0", 64'({mclk0, bclk0, lrclk0}), 64'({cyc[1], cyc[3], cyc[9]}));
      chk("clocks1", 64'({mclk1, bclk1, lrclk1}), 64'({clk, cyc[1], cyc[7]}));
      if (sv0) check_sv(0);
      if (sv1) check_sv(1);
    end
  endtask

  task automatic release_reset();
    reset      = 1'b0;
    cyc        = 0;
    last_sv[0] = -1;
    last_sv[1] = -1;
    nsv[0]     = 0;
    nsv[1]     = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out0"}, 64'({left0, right0, sv0}), 64'(0));
    chk({tag, "_out1"}, 64'({left1, right1, sv1}), 64'(0));
    chk({tag, "_clk0"}, 64'({mclk0, bclk0, lrclk0}), 64'(0));
    chk({tag, "_clk1"}, 64'({bclk1, lrclk1}), 64'(0));
  endtask

  initial begin
    sd0 = 1'b0;
    sd1 = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    release_reset();
    run_cycles(6 * 1024);
    chk("count0", 64'(nsv[0]), 64'(5));
    chk("count1", 64'(nsv[1]), 64'(24));

    // Reset in the middle of DUT0's right half
    run_cycles(700);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (3) begin
      @(negedge clk);
      chk("midreset_sv", 64'({sv0, sv1}), 64'(0));
    end
    release_reset();
    run_cycles(4 * 1024);
    chk("count0_after_reset", 64'(nsv[0]), 64'(3));
    chk("count1_after_reset", 64'(nsv[1]), 64'(16));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
